gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter DATA_W, default 32: width of GPIO data paths.
REQ-002 Parameter DEPTH, default 2: write-buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 gpio_out_en  input  1  EX-stage GPIO write request (srl with shamt 0).
REQ-006 gpio_in_en  input  1  EX-stage GPIO read request (sra with shamt 0).
REQ-007 wdata  input  DATA_W  value to write, from register-file read port 1 in EX.
REQ-008 rdata  output  DATA_W  captured GPIO input value, to writeback mux.
REQ-009 stall  output  1  holds fetch/EX when a write cannot be accepted.
REQ-010 gpio_out  output  DATA_W  external output pins.
REQ-011 gpio_out_valid  output  1  gpio_out holds an unacknowledged word.
REQ-012 gpio_out_ack  input  1  external device consumed gpio_out this cycle.
REQ-013 gpio_in  input  DATA_W  external input pins, asynchronous to clk.

Function
REQ-014 Write path SHALL be a DEPTH-entry FIFO with head/tail pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-015 Push SHALL occur when gpio_out_en=1 and stall=0.
REQ-016 Pop SHALL occur when gpio_out_valid=1 and gpio_out_ack=1.
REQ-017 gpio_out_valid SHALL equal (count != 0).
REQ-018 gpio_out SHALL present the head entry while non-empty; when empty it SHALL hold the last popped word.
REQ-019 stall SHALL be combinational: gpio_out_en & full & ~(gpio_out_valid & gpio_out_ack).
REQ-020 Full with simultaneous push and pop SHALL accept both; count unchanged; no stall.
REQ-021 Empty with push SHALL present the pushed word on gpio_out with valid=1 in the next cycle; there is no bypass in the same cycle.
REQ-022 Pointers SHALL wrap modulo DEPTH. Overflow and underflow SHALL be impossible by construction.
REQ-023 An ack while empty SHALL be ignored.
REQ-024 gpio_in SHALL pass through a 2-flop synchronizer before use.
REQ-025 When gpio_in_en=1, rdata SHALL load the synchronized value at the clock edge. Otherwise rdata holds.
REQ-026 Read latency SHALL be 1 clk from gpio_in_en to rdata, plus 2 clk of pin-to-sync delay.
REQ-027 gpio_in_en and gpio_out_en asserted together SHALL both be serviced independently.
REQ-028 A read SHALL never be stalled.

Reset
REQ-029 While rst=0 the block SHALL hold: count, pointers, gpio_out, rdata and synchronizer flops all at 0, and gpio_out_valid=0.
REQ-030 Reset SHALL take effect immediately, including mid-transfer; buffered words SHALL be discarded.
REQ-031 Reset release SHALL be treated as synchronous to clk; the first push is accepted on the first edge with rst=1.
REQ-032 stall SHALL be 0 during reset.

Structure
REQ-033 A shared package gpio_pkg SHALL hold GPIO_DATA_W (32), GPIO_DEPTH (2) and the FIFO pointer/count typedefs.
REQ-034 The synchronizer SHALL be a sub-module named sync2 (DATA_W wide, async active-low reset).
REQ-035 The FIFO SHALL be inline in gpio_port; it SHALL NOT be a separate module.

Verification
REQ-036 Reset, then gpio_out_en=1 with wdata=0x0000_00A5 and ack=0 -> next cycle gpio_out=0x0000_00A5, valid=1, stall=0.
REQ-037 Three consecutive writes 0x1, 0x2, 0x3 with ack=0 -> the third cycle asserts stall=1. Then ack=1 for one cycle -> 0x3 accepted, gpio_out=0x2, count=2.
REQ-038 Full buffer with push 0x7 and ack on the same cycle -> stall=0, count stays 2, order preserved.
REQ-039 gpio_in changes to 0xDEAD_BEEF at cycle t, gpio_in_en=1 from t+2 -> rdata=0xDEAD_BEEF at t+3; gpio_in_en=1 at t only -> rdata retains its old value.
REQ-040 Two words buffered, rst pulled low between edges -> gpio_out=0, valid=0 and rdata=0 immediately, with no clock edge needed.
REQ-041 gpio_out_en and gpio_in_en both high with wdata=0x55 -> both the write and the read complete; stall=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and types for the GPIO port.
//   GPIO_DATA_W - default GPIO data width
//   GPIO_DEPTH  - default write-buffer depth (power of two, >= 2)
//   gpio_ptr_t  - write-buffer pointer type for the default depth
//   gpio_cnt_t  - write-buffer occupancy type for the default depth
//                 (one bit wider than a pointer so "full" is representable)
package gpio_pkg;

  localparam int GPIO_DATA_W = 32;
  localparam int GPIO_DEPTH  = 2;
  localparam int GPIO_PTR_W  = $clog2(GPIO_DEPTH);

  typedef logic [GPIO_PTR_W-1:0] gpio_ptr_t;
  typedef logic [GPIO_PTR_W:0]   gpio_cnt_t;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a DATA_W-wide bus sampled from an
// asynchronous domain.
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset, clears both flop stages
//   async_in - bus from the foreign domain
//   sync_out - bus retimed into the clk domain (2 clk latency)
module sync2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] async_in,
  output logic [DATA_W-1:0] sync_out
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  // stage 0: first capture, may go metastable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= async_in;
  end

  // stage 1: settled value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p1 <= '0;
    else        sync_p1 <= sync_p0;
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/gpio_port.sv
// gpio_port: CPU-side GPIO block.  Writes from EX go into a small FIFO that
// drains to the output pins under a valid/ack handshake; reads capture the
// synchronized input pins into rdata.
//   clk            - single clock, rising edge
//   rst            - asynchronous active-low reset
//   gpio_out_en    - EX-stage write request
//   gpio_in_en     - EX-stage read request (never stalled)
//   wdata          - word to write
//   rdata          - captured input value for writeback
//   stall          - write cannot be accepted this cycle (combinational)
//   gpio_out       - head word, or last drained word when empty
//   gpio_out_valid - gpio_out holds an unacknowledged word
//   gpio_out_ack   - external device consumed gpio_out this cycle
//   gpio_in        - asynchronous input pins
module gpio_port
  import gpio_pkg::*;
#(
  parameter int DATA_W = GPIO_DATA_W,
  parameter int DEPTH  = GPIO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpio_out_en,
  input  logic              gpio_in_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic [DATA_W-1:0] gpio_out,
  output logic              gpio_out_valid,
  input  logic              gpio_out_ack,
  input  logic [DATA_W-1:0] gpio_in
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] last_word;
  logic [DATA_W-1:0] gpio_in_sync;
  logic              full;
  logic              push;
  logic              pop;

  assign full           = (count == FULL_CNT);
  assign gpio_out_valid = (count != '0);
  assign pop            = gpio_out_valid & gpio_out_ack;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign stall          = gpio_out_en & full & ~pop;
  assign push           = gpio_out_en & ~stall;

  // Empty buffer shows the last drained word; count is 0 in reset and
  // last_word is cleared, so the pins read 0 immediately on reset.
  assign gpio_out = gpio_out_valid ? mem[rd_ptr] : last_word;

  // write buffer: storage is data only, not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // write buffer: pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  sync2 #(
    .DATA_W (DATA_W)
  ) u_sync2 (
    .clk      (clk),
    .rst_n    (rst),
    .async_in (gpio_in),
    .sync_out (gpio_in_sync)
  );

  // read capture: one clock after the request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rdata <= '0;
    else if (gpio_in_en) rdata <= gpio_in_sync;
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed bench for gpio_port with a queue-based reference
// model checked on every falling edge, plus literal expectations.
module tb_gpio_port;

  localparam int DW = 32;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gpio_out_en = 1'b0;
  logic          gpio_in_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          stall;
  logic [DW-1:0] gpio_out;
  logic          gpio_out_valid;
  logic          gpio_out_ack = 1'b0;
  logic [DW-1:0] gpio_in = '0;

  int checks = 0;
  int failures = 0;

  gpio_port #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk            (clk),
    .rst            (rst),
    .gpio_out_en    (gpio_out_en),
    .gpio_in_en     (gpio_in_en),
    .wdata          (wdata),
    .rdata          (rdata),
    .stall          (stall),
    .gpio_out       (gpio_out),
    .gpio_out_valid (gpio_out_valid),
    .gpio_out_ack   (gpio_out_ack),
    .gpio_in        (gpio_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered words, the last drained word, and
  // the pin values seen at the two most recent edges.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_m = '0;
  logic [DW-1:0] rdata_m = '0;
  logic [DW-1:0] pin_hist[2] = '{default: '0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      last_m   = '0;
      rdata_m  = '0;
      pin_hist = '{default: '0};
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() != 0) && gpio_out_ack;
      do_push = gpio_out_en && ((q.size() < DP) || do_pop);
      if (gpio_in_en) rdata_m = pin_hist[1];
      if (do_pop) last_m = q.pop_front();
      if (do_push) q.push_back(wdata);
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = gpio_in;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_out;
    logic          exp_vld;
    logic          exp_stall;
    exp_vld   = (q.size() != 0);
    exp_out   = exp_vld ? q[0] : last_m;
    exp_stall = rst && gpio_out_en && (q.size() == DP) && !(exp_vld && gpio_out_ack);
    chk("model_gpio_out", gpio_out, exp_out);
    chk("model_valid", DW'(gpio_out_valid), DW'(exp_vld));
    chk("model_stall", DW'(stall), DW'(exp_stall));
    chk("model_rdata", rdata, rdata_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, stall held low even with a write request
    gpio_out_en = 1'b1;
    wdata = 32'hFFFF_FFFF;
    gpio_in = 32'h1234_5678;
    tick();
    tick();
    tick();
    chk("reset_gpio_out", gpio_out, 32'h0);
    chk("reset_valid", DW'(gpio_out_valid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_stall", DW'(stall), 32'h0);
    gpio_out_en = 1'b0;
    rst = 1'b1;

    // single write appears next cycle
    gpio_out_en = 1'b1;
    wdata = 32'h0000_00A5;
    #1 chk("a5_stall", DW'(stall), 32'h0);
    tick();
    gpio_out_en = 1'b0;
    chk("a5_gpio_out", gpio_out, 32'h0000_00A5);
    chk("a5_valid", DW'(gpio_out_valid), 32'h1);

    // drain: empty holds last popped word
    gpio_out_ack = 1'b1;
    tick();
    gpio_out_ack = 1'b0;
    chk("drain_hold", gpio_out, 32'h0000_00A5);
    chk("drain_valid", DW'(gpio_out_valid), 32'h0);
    // ack while empty is ignored
    gpio_out_ack = 1'b1;
    tick();
    gpio_out_ack = 1'b0;
    chk("empty_ack_hold", gpio_out, 32'h0000_00A5);

    // fill and stall
    gpio_out_en = 1'b1;
    wdata = 32'h1;
    tick();
    wdata = 32'h2;
    tick();
    wdata = 32'h3;
    #1 chk("full_stall", DW'(stall), 32'h1);
    tick();
    chk("full_head", gpio_out, 32'h1);
    gpio_out_ack = 1'b1;
    #1 chk("full_ack_nostall", DW'(stall), 32'h0);
    tick();
    gpio_out_en = 1'b0;
    gpio_out_ack = 1'b0;
    chk("after_ack_head", gpio_out, 32'h2);
    chk("after_ack_count", DW'(dut.count), 32'h2);
    chk("model_depth", DW'(q.size()), 32'h2);

    // full with push and pop together
    gpio_out_en = 1'b1;
    gpio_out_ack = 1'b1;
    wdata = 32'h7;
    #1 chk("pushpop_stall", DW'(stall), 32'h0);
    tick();
    gpio_out_en = 1'b0;
    gpio_out_ack = 1'b0;
    chk("pushpop_count", DW'(dut.count), 32'h2);
    chk("pushpop_head", gpio_out, 32'h3);
    gpio_out_ack = 1'b1;
    tick();
    chk("order_7", gpio_out, 32'h7);
    tick();
    gpio_out_ack = 1'b0;
    chk("order_empty_hold", gpio_out, 32'h7);
    chk("order_empty_valid", DW'(gpio_out_valid), 32'h0);

    // simultaneous write and read
    gpio_out_en = 1'b1;
    gpio_in_en = 1'b1;
    wdata = 32'h55;
    #1 chk("both_stall", DW'(stall), 32'h0);
    tick();
    gpio_out_en = 1'b0;
    gpio_in_en = 1'b0;
    chk("both_write", gpio_out, 32'h55);
    chk("both_read", rdata, 32'h1234_5678);
    gpio_out_ack = 1'b1;
    tick();
    gpio_out_ack = 1'b0;

    // synchronizer latency
    gpio_in = 32'hDEAD_BEEF;
    gpio_in_en = 1'b1;
    tick();
    gpio_in_en = 1'b0;
    chk("sync_early_read", rdata, 32'h1234_5678);
    tick();
    gpio_in_en = 1'b1;
    tick();
    gpio_in_en = 1'b0;
    chk("sync_read", rdata, 32'hDEAD_BEEF);

    // mixed traffic checked by the model
    for (int i = 0; i < 48; i++) begin
      gpio_out_en  = ($urandom_range(0, 3) != 0);
      gpio_out_ack = ($urandom_range(0, 2) == 0);
      gpio_in_en   = ($urandom_range(0, 1) == 1);
      wdata        = $urandom;
      if (i % 5 == 0) gpio_in = $urandom;
      tick();
    end
    gpio_out_en = 1'b0;
    gpio_out_ack = 1'b0;
    gpio_in_en = 1'b0;

    // async reset mid-cycle with two buffered words
    gpio_out_en = 1'b1;
    wdata = 32'h11;
    tick();
    wdata = 32'h22;
    tick();
    gpio_out_en = 1'b0;
    gpio_in_en = 1'b1;
    tick();
    gpio_in_en = 1'b0;
    chk("prereset_valid", DW'(gpio_out_valid), 32'h1);
    #2 rst = 1'b0;
    gpio_out_en = 1'b1;
    #1;
    chk("async_rst_gpio_out", gpio_out, 32'h0);
    chk("async_rst_valid", DW'(gpio_out_valid), 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_stall", DW'(stall), 32'h0);
    tick();
    rst = 1'b1;
    wdata = 32'h99;
    tick();
    gpio_out_en = 1'b0;
    chk("first_push_after_rst", gpio_out, 32'h99);
    chk("first_push_valid", DW'(gpio_out_valid), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
